// File: rtl/text_pkg.sv
// Shared constants, pixel type and the character-cell address helper for
// the text renderer.
package text_pkg;

  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;
  localparam int COLS     = 80;
  localparam int ROWS     = 30;
  localparam int PIPE_LAT = 5;
  localparam int RGB_W    = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  // row*80 + col built from two shifts (64 + 16) so no multiplier is inferred.
  // The 13-bit result lets the caller see addresses beyond 4095 and saturate.
  function automatic logic [12:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    return {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {6'b0, col};
  endfunction

endpackage

// File: rtl/text_sync_delay.sv
// sync_delay: fixed-depth shift register with asynchronous reset to a
// configurable value. Used to carry syncs, DE and coordinate low bits
// alongside the character/font lookups.
module sync_delay #(
  parameter int                WIDTH   = 1,
  parameter int                DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Shift d through DEPTH registers; reset loads every tap with RST_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= RST_VAL;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/text_renderer.sv
// text_renderer: 80x30 text-mode pixel generator. Five-stage pipeline:
// cell address -> char RAM -> font address -> font ROM -> pixel colour.
// Optional blinking underline cursor when TEXT_CURSOR_EN is defined.
module text_renderer
  import text_pkg::*;
#(
  parameter int   COLS      = text_pkg::COLS,
  parameter int   ROWS      = text_pkg::ROWS,
  parameter rgb_t FG_COLOR  = 12'hFFF,
  parameter rgb_t BG_COLOR  = 12'h000,
  parameter int   BLINK_DIV = 30
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic        i_de,
  input  logic        i_hsync,
  input  logic        i_vsync,
`ifdef TEXT_CURSOR_EN
  input  logic [6:0]  i_cur_col,
  input  logic [4:0]  i_cur_row,
`endif
  output logic [11:0] o_ram_addr,
  input  logic [7:0]  i_ram_data,
  output logic [11:0] o_font_addr,
  input  logic [7:0]  i_font_data,
  output rgb_t        o_rgb,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_wr_ok
);

  localparam logic [9:0] TEXT_H = 10'(ROWS * CHAR_H);

  logic [5:0]  row;
  logic [6:0]  col;
  logic [12:0] addr_full;
  logic        vis;
  logic        cur_hit;
  logic        blink;

  assign row = i_y[9:4];
  assign col = i_x[9:3];
  // Pixels below the text area or outside active video are forced black at S5.
  assign vis = i_de && (i_y < TEXT_H);

  if (COLS == 80) begin : g_addr_shift
    assign addr_full = cell_addr(row, col);
  end else begin : g_addr_mul
    assign addr_full = 13'(int'(row) * COLS + int'(col));
  end

`ifdef TEXT_CURSOR_EN
  logic       vsync_prev;
  logic [7:0] frame_cnt;

  // Count frames on vsync falling edges; toggle the blink phase every BLINK_DIV frames.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vsync_prev <= 1'b1;
      frame_cnt  <= '0;
      blink      <= 1'b0;
    end else begin
      vsync_prev <= i_vsync;
      if (vsync_prev && !i_vsync) begin
        if (frame_cnt == 8'(BLINK_DIV - 1)) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  assign cur_hit = (row == {1'b0, i_cur_row}) && (col == i_cur_col);
`else
  logic unused_cfg;
  assign unused_cfg = ^BLINK_DIV;
  assign blink      = 1'b0;
  assign cur_hit    = 1'b0;
`endif

  // Lane carried to S5: cursor hit, visibility, pixel-in-glyph x, glyph row.
  logic [8:0] lane_d4;
  logic [3:0] y_d2;
  logic [2:0] x_d4;
  logic [3:0] y_d4;
  logic       vis_d4;
  logic       hit_d4;
  logic       font_bit;

  sync_delay #(.WIDTH(9), .DEPTH(PIPE_LAT - 1), .RST_VAL(9'd0)) u_lane (
    .clk (i_clk),
    .rst (i_rst),
    .d   ({cur_hit, vis, i_x[2:0], i_y[3:0]}),
    .q   (lane_d4)
  );

  sync_delay #(.WIDTH(4), .DEPTH(2), .RST_VAL(4'd0)) u_glyph_row (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_y[3:0]),
    .q   (y_d2)
  );

  // Syncs idle high, DE idle low, so a flushed pipeline emits blank syncs.
  sync_delay #(.WIDTH(3), .DEPTH(PIPE_LAT), .RST_VAL(3'b011)) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   ({i_de, i_hsync, i_vsync}),
    .q   ({o_de, o_hsync, o_vsync})
  );

  assign {hit_d4, vis_d4, x_d4, y_d4} = lane_d4;

  // Glyph bit, MSB leftmost; cursor inverts the bottom two glyph rows.
  assign font_bit = i_font_data[3'd7 - x_d4] ^ (blink & hit_d4 & (y_d4[3:1] == 3'b111));

  // S1 cell address (saturating), S3 font address, write window flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ram_addr  <= '0;
      o_font_addr <= '0;
      o_wr_ok     <= 1'b0;
    end else begin
      o_ram_addr  <= (addr_full > 13'd4095) ? 12'hFFF : addr_full[11:0];
      o_font_addr <= {i_ram_data, y_d2};
      o_wr_ok     <= (i_y >= TEXT_H);
    end
  end

  // S5 pixel colour.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rgb <= '0;
    end else begin
      o_rgb <= vis_d4 ? (font_bit ? FG_COLOR : BG_COLOR) : rgb_t'(0);
    end
  end

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer: behavioural char RAM / font ROM,
// a scoreboard of expected pixels/syncs, and per-feature test tasks.
// Build with TEXT_CURSOR_EN defined to also exercise the cursor.
module tb_text_renderer;

  localparam int BLINK = 2;
  localparam int CUR_C = 3;
  localparam int CUR_R = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  i_x = '0, i_y = '0;
  logic        i_de = 1'b0, i_hsync = 1'b1, i_vsync = 1'b1;
  logic [11:0] o_ram_addr, o_font_addr, o_rgb;
  logic [7:0]  ram_q = '0, rom_q = '0;
  logic        o_de, o_hsync, o_vsync, o_wr_ok;
`ifdef TEXT_CURSOR_EN
  logic [6:0]  cur_col = 7'(CUR_C);
  logic [4:0]  cur_row = 5'(CUR_R);
`endif

  always #5 clk = ~clk;

  text_renderer #(.BLINK_DIV(BLINK)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_x         (i_x),
    .i_y         (i_y),
    .i_de        (i_de),
    .i_hsync     (i_hsync),
    .i_vsync     (i_vsync),
`ifdef TEXT_CURSOR_EN
    .i_cur_col   (cur_col),
    .i_cur_row   (cur_row),
`endif
    .o_ram_addr  (o_ram_addr),
    .i_ram_data  (ram_q),
    .o_font_addr (o_font_addr),
    .i_font_data (rom_q),
    .o_rgb       (o_rgb),
    .o_de        (o_de),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_wr_ok     (o_wr_ok)
  );

  // Memories with one clock of read latency.
  logic [7:0] ram  [4096];
  logic [7:0] font [4096];
  always @(posedge clk) begin
    ram_q <= ram[o_ram_addr];
    rom_q <= font[o_font_addr];
  end

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        de, hs, vs;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   prev_vs = 1'b1;
  int   frames = 0;
  bit   cur_flag = 1'b0;

  // Reference pixel: character cell lookup, glyph bit, cursor, blanking.
  function automatic logic [11:0] model_rgb(int x, int y, bit de);
    int         addr;
    logic [7:0] code, glyph;
    logic [3:0] gr;
    bit         b;
    if (!de || y >= 480) return 12'h000;
    addr  = (y / 16) * 80 + (x / 8);
    code  = ram[addr];
    gr    = 4'(y % 16);
    glyph = font[{code, gr}];
    b     = glyph[7 - (x % 8)];
    if (cur_flag && (y / 16) == CUR_R && (x / 8) == CUR_C && (y % 16) >= 14) b = ~b;
    return b ? 12'hFFF : 12'h000;
  endfunction

  // Scoreboard: compare every output due on this clock, 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (!rst && sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        vectors++;
        if ({o_rgb, o_de, o_hsync, o_vsync} !== {e.rgb, e.de, e.hs, e.vs}) begin
          miscompares++;
          $display("FAIL pixel cyc=%0d got rgb=%h de=%b hs=%b vs=%b, expected rgb=%h de=%b hs=%b vs=%b",
                   cyc, o_rgb, o_de, o_hsync, o_vsync, e.rgb, e.de, e.hs, e.vs);
        end
      end
    end
  end

  // Apply one pixel now and push its expected output 5 clocks later.
  task automatic drive(int x, int y, bit de, bit hs, bit vs);
    exp_t e;
`ifdef TEXT_CURSOR_EN
    if (prev_vs && !vs) begin
      frames++;
      if (frames == BLINK) begin
        frames   = 0;
        cur_flag = ~cur_flag;
      end
    end
`endif
    prev_vs = vs;
    i_x = 10'(x); i_y = 10'(y); i_de = de; i_hsync = hs; i_vsync = vs;
    e.due = cyc + 5;
    e.rgb = model_rgb(x, y, de);
    e.de = de; e.hs = hs; e.vs = vs;
    sb.push_back(e);
  endtask

  task automatic step(int x, int y, bit de, bit hs, bit vs);
    @(negedge clk);
    drive(x, y, de, hs, vs);
  endtask

  task automatic drain;
    repeat (6) step(0, 500, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic assert_reset;
    @(negedge clk);
    #2 rst = 1'b1;
    frames = 0;
    cur_flag = 1'b0;
    sb.delete();
  endtask

  // Release at a falling edge; the four flushed outputs before the first pixel are blank.
  task automatic release_reset;
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    prev_vs = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      e.due = cyc + k; e.rgb = 12'h000; e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
      sb.push_back(e);
    end
    drive(0, 0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset;
    int n;
    // power-on values
    @(negedge clk);
    n = 0;
    if (o_rgb !== 12'h000)      begin n++; $display("FAIL por_rgb got %h want 000", o_rgb); end
    if (o_de !== 1'b0)          begin n++; $display("FAIL por_de got %b want 0", o_de); end
    if (o_hsync !== 1'b1)       begin n++; $display("FAIL por_hsync got %b want 1", o_hsync); end
    if (o_vsync !== 1'b1)       begin n++; $display("FAIL por_vsync got %b want 1", o_vsync); end
    if (o_wr_ok !== 1'b0)       begin n++; $display("FAIL por_wr_ok got %b want 0", o_wr_ok); end
    if (o_ram_addr !== 12'h0)   begin n++; $display("FAIL por_ram_addr got %h want 000", o_ram_addr); end
    if (o_font_addr !== 12'h0)  begin n++; $display("FAIL por_font_addr got %h want 000", o_font_addr); end
    vectors += 7; miscompares += n;
    release_reset();
    for (int k = 1; k < 8; k++) step(k, 0, 1'b1, 1'b1, 1'b1);
    // mid-line reset while outputs are busy
    repeat (6) step(0, 0, 1'b1, 1'b0, 1'b0);
    step(0, 490, 1'b0, 1'b0, 1'b0);
    assert_reset();
    #1;
    n = 0;
    if (o_rgb !== 12'h000)      begin n++; $display("FAIL rst_rgb got %h want 000", o_rgb); end
    if (o_de !== 1'b0)          begin n++; $display("FAIL rst_de got %b want 0", o_de); end
    if (o_hsync !== 1'b1)       begin n++; $display("FAIL rst_hsync got %b want 1", o_hsync); end
    if (o_vsync !== 1'b1)       begin n++; $display("FAIL rst_vsync got %b want 1", o_vsync); end
    if (o_wr_ok !== 1'b0)       begin n++; $display("FAIL rst_wr_ok got %b want 0", o_wr_ok); end
    if (o_ram_addr !== 12'h0)   begin n++; $display("FAIL rst_ram_addr got %h want 000", o_ram_addr); end
    if (o_font_addr !== 12'h0)  begin n++; $display("FAIL rst_font_addr got %h want 000", o_font_addr); end
    vectors += 7; miscompares += n;
    repeat (2) @(negedge clk);
    release_reset();
    for (int k = 1; k < 8; k++) step(k, 0, 1'b1, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_address;
    int ax [5] = '{639, 8, 632, 0, 100};
    int ay [5] = '{479, 16, 0, 479, 37};
    int ea [5] = '{2399, 81, 79, 2320, 172};
    for (int k = 0; k < 5; k++) begin
      step(ax[k], ay[k], 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      vectors++;
      if (o_ram_addr !== 12'(ea[k])) begin
        miscompares++;
        $display("FAIL ram_addr x=%0d y=%0d got %0d want %0d", ax[k], ay[k], o_ram_addr, ea[k]);
      end
    end
    drain();
  endtask

  task automatic test_glyph;
    for (int k = 0; k < 8; k++) step(k, 0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    vectors++;
    if (o_font_addr !== 12'h410) begin
      miscompares++;
      $display("FAIL font_addr got %h want 410", o_font_addr);
    end
    drain();
  endtask

  task automatic test_alignment;
    for (int k = 0; k < 10; k++)  step(k, 500, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 96; k++)  step(k, 500, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++)  step(k, 500, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++)   step(k, 490, 1'b0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_blanking;
    int ty [5] = '{0, 479, 480, 500, 524};
    for (int i = 0; i < 4096; i++) font[i] = 8'hFF;
    for (int k = 0; k < 16; k++) step(k, 100, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) step(k, 100, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(16, ty[k], 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      vectors++;
      if (o_wr_ok !== (ty[k] >= 480)) begin
        miscompares++;
        $display("FAIL wr_ok y=%0d got %b want %b", ty[k], o_wr_ok, (ty[k] >= 480));
      end
    end
    drain();
    for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
    font[12'h410] = 8'h81;
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 639), $urandom_range(0, 524), 1'($urandom), 1'($urandom), 1'b1);
    drain();
  endtask

`ifdef TEXT_CURSOR_EN
  task automatic test_cursor;
    ram[CUR_R * 80 + CUR_C] = 8'h00;
    for (int r = 0; r < 16; r++) font[r] = 8'h00;
    assert_reset();
    repeat (2) @(negedge clk);
    release_reset();
    drain();
    for (int f = 0; f < 8; f++) begin
      for (int y = 45; y < 48; y++)
        for (int x = 24; x < 32; x++) step(x, y, 1'b1, 1'b1, 1'b1);
      drain();
      step(0, 490, 1'b0, 1'b1, 1'b0);
      step(0, 490, 1'b0, 1'b1, 1'b0);
      drain();
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = 8'($urandom);
      font[i] = 8'($urandom);
    end
    ram[0]        = 8'h41;
    font[12'h410] = 8'h81;

    test_reset();
    test_address();
    test_glyph();
    test_alignment();
    test_blanking();
    test_back_to_back();
`ifdef TEXT_CURSOR_EN
    test_cursor();
`endif
    drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain %0d outputs never checked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
